uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing one UART transmitter; the legal range is 2 to 8.
REQ-002 Parameter TIMEOUT_CLOCKS, default 4000, is the maximum number of cycles a transfer may spend waiting on the transmitter.
REQ-003 Port i_clock  input  1  is the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port i_resetN  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port i_reqValid  input  NUM_REQ  indicates that requester k has a byte pending.
REQ-006 Port i_reqData  input  8*NUM_REQ  carries the packed bytes; requester k SHALL occupy bits [8k+7:8k].
REQ-007 Port o_reqReady  output  NUM_REQ  is a one-hot, one-cycle pulse meaning that the requester's byte has been accepted.
REQ-008 Port o_grant  output  NUM_REQ  is the one-hot owner of the transmitter; it SHALL be all zeros when the transmitter is unowned.
REQ-009 Port o_txBegin  output  1  is the start strobe to the transmitter.
REQ-010 Port o_txData  output  8  is the byte presented to the transmitter.
REQ-011 Port i_txBusy  input  1  is the transmitter busy flag.
REQ-012 Port i_txDone  input  1  is the transmitter's one-cycle completion pulse.
REQ-013 Port o_timeout  output  1  is a one-cycle pulse indicating that a transfer was abandoned.
REQ-014 Port o_sentCount  output  16  is the running count of completed bytes.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE with i_txBusy=0 and any i_reqValid bit set, the block SHALL select the first set bit searching upward from (lastGrant+1) mod NUM_REQ, wrapping around.
REQ-017 On selection (IDLE, cycle n), o_reqReady[k], o_grant[k] and o_txData=byte k SHALL all be valid in cycle n+1, and the state SHALL become LAUNCH.
REQ-018 In LAUNCH, o_txBegin SHALL be 1 for exactly one cycle (cycle n+2), o_txData SHALL be held, and the state SHALL become WAIT_BUSY.
REQ-019 o_txData and o_grant SHALL remain stable from cycle n+1 until the state returns to IDLE.
REQ-020 In WAIT_BUSY, i_txBusy=1 SHALL cause a transition to WAIT_DONE.
REQ-021 In WAIT_BUSY or WAIT_DONE, i_txDone=1 SHALL complete the transfer, even if busy was never observed.
REQ-022 On completion, o_sentCount SHALL increment (wrapping 65535 to 0), lastGrant SHALL become k, o_grant SHALL clear, and the state SHALL become IDLE.
REQ-023 A 16-bit wait counter SHALL clear on entry to WAIT_BUSY and increment each cycle in WAIT_BUSY or WAIT_DONE.
REQ-024 When the wait counter reaches TIMEOUT_CLOCKS, the block SHALL pulse o_timeout for one cycle, set lastGrant to k, clear o_grant, leave o_sentCount unchanged, and return to IDLE.
REQ-025 If i_txDone=1 and the timeout occur in the same cycle, completion SHALL take priority and o_timeout SHALL stay 0.
REQ-026 i_txDone in IDLE or LAUNCH SHALL be ignored.
REQ-027 IDLE SHALL NOT arbitrate while i_txBusy=1, so that back-to-back launches never collide with the transmitter's cleanup.
REQ-028 i_reqValid SHALL be sampled only in IDLE; deassertion after acceptance SHALL NOT affect the transfer in progress.
REQ-029 At most one o_reqReady bit SHALL be set per cycle, and at most one o_txBegin SHALL occur per accepted byte.
REQ-030 With all requesters continuously valid, grants SHALL rotate 0,1,...,NUM_REQ-1,0 with no requester skipped.

Reset
REQ-031 While i_resetN=0, all outputs SHALL be 0, the state SHALL be IDLE, lastGrant SHALL be NUM_REQ-1, and the counters SHALL be 0, regardless of the clock.
REQ-032 Reset asserted mid-transfer SHALL drop the accepted byte without a completion count, and SHALL NOT produce o_txBegin after release until a new arbitration occurs.
REQ-033 After reset release, requester 0 SHALL have the highest priority.

Verification
REQ-034 Single request: req1 valid with 0xA5, model transmitter -> ready[1] at n+1, txBegin at n+2 with txData=0xA5, sentCount=1 after txDone.
REQ-035 Fairness: all 4 valid for 8 transfers -> grant order 0,1,2,3,0,1,2,3 and sentCount=8.
REQ-036 Timeout: transmitter never busy and never done, TIMEOUT_CLOCKS=50 -> o_timeout pulses once 50 cycles after WAIT_BUSY entry, sentCount unchanged, next grant goes to k+1.
REQ-037 Collision: txDone and timeout in the same cycle -> sentCount increments and o_timeout=0.
REQ-038 Reset mid-transfer: i_resetN low during WAIT_DONE -> all outputs 0 asynchronously, sentCount=0, and no txBegin after release until a new request.
REQ-039 Busy hold-off: i_txBusy held 1 in IDLE with req0 valid -> no ready and no txBegin until busy drops, then ready[0] on the next cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NUM_REQ requesters
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CLOCKS = 4000
) (
   input  logic                 i_clock,
   input  logic                 i_resetN,
   input  logic [NUM_REQ-1:0]   i_reqValid,
   input  logic [8*NUM_REQ-1:0] i_reqData,
   output logic [NUM_REQ-1:0]   o_reqReady,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic                 o_txBegin,
   output logic [7:0]           o_txData,
   input  logic                 i_txBusy,
   input  logic                 i_txDone,
   output logic                 o_timeout,
   output logic [15:0]          o_sentCount
);

   localparam int          IDX_W         = $clog2(NUM_REQ);
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CLOCKS);
   localparam logic [NUM_REQ-1:0] ONE    = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   state_t           state, state_next;
   logic [IDX_W-1:0] last_grant, cur_idx, sel_idx, cand_idx;
   logic [7:0]       sel_byte;
   logic [15:0]      wait_cnt;
   int               cand;
   logic             sel_found, waiting, done_hit, abandon, select;

   // Rotating search starting just above the previous owner.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = int'(last_grant) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!sel_found && i_reqValid[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      sel_byte = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (sel_idx == IDX_W'(k)) sel_byte = i_reqData[8*k +: 8];
      end
   end

   assign waiting   = (state == WAIT_BUSY) || (state == WAIT_DONE);
   assign done_hit  = waiting && i_txDone;
   // Completion wins over a timeout landing in the same cycle.
   assign abandon   = waiting && !i_txDone && (wait_cnt == TIMEOUT_LIMIT);
   assign select    = (state == IDLE) && !i_txBusy && sel_found;
   assign o_timeout = abandon;

   always_ff @(posedge i_clock or negedge i_resetN) begin
      if (!i_resetN) state <= IDLE;
      else           state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (select) state_next = LAUNCH;
         LAUNCH:    state_next = WAIT_BUSY;
         WAIT_BUSY: begin
            if (done_hit || abandon) state_next = IDLE;
            else if (i_txBusy)       state_next = WAIT_DONE;
         end
         WAIT_DONE: if (done_hit || abandon) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_resetN) begin
      if (!i_resetN) begin
         last_grant  <= IDX_W'(NUM_REQ - 1);
         cur_idx     <= '0;
         o_reqReady  <= '0;
         o_grant     <= '0;
         o_txData    <= '0;
         o_txBegin   <= 1'b0;
         wait_cnt    <= '0;
         o_sentCount <= '0;
      end else begin
         o_reqReady <= select ? (ONE << sel_idx) : '0;
         o_txBegin  <= (state == LAUNCH);
         if (select) begin
            cur_idx  <= sel_idx;
            o_grant  <= ONE << sel_idx;
            o_txData <= sel_byte;
         end
         if (done_hit || abandon) begin
            last_grant <= cur_idx;
            o_grant    <= '0;
         end
         if (done_hit) o_sentCount <= o_sentCount + 16'd1;
         if (state == LAUNCH)  wait_cnt <= '0;
         else if (waiting)     wait_cnt <= wait_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        resetN;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [3:0]  grant;
   logic        tx_begin;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        tx_done;
   logic        timeout;
   logic [15:0] sent_count;

   int compared   = 0;
   int mismatched = 0;
   int early;
   logic [7:0] fair_bytes [4] = '{8'h11, 8'hA5, 8'h33, 8'h44};

   uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CLOCKS(50)) dut (
      .i_clock    (clk),
      .i_resetN   (resetN),
      .i_reqValid (req_valid),
      .i_reqData  (req_data),
      .o_reqReady (req_ready),
      .o_grant    (grant),
      .o_txBegin  (tx_begin),
      .o_txData   (tx_data),
      .i_txBusy   (tx_busy),
      .i_txDone   (tx_done),
      .o_timeout  (timeout),
      .o_sentCount(sent_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      resetN    = 1'b0;
      req_valid = '0;
      req_data  = {8'h44, 8'h33, 8'hA5, 8'h11};
      tx_busy   = 1'b0;
      tx_done   = 1'b0;
      tick;
      tick;
      chk("rst_grant", grant, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_begin", tx_begin, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_count", sent_count, 0);
      resetN = 1'b1;

      // single request on requester 1, transmitter goes busy then done
      req_valid = 4'b0010;
      tick;
      chk("a_ready", req_ready, 4'b0010);
      chk("a_grant", grant, 4'b0010);
      chk("a_data", tx_data, 8'hA5);
      chk("a_begin_n1", tx_begin, 0);
      req_valid = '0;
      tick;
      chk("a_begin_n2", tx_begin, 1);
      chk("a_ready_once", req_ready, 0);
      chk("a_data_n2", tx_data, 8'hA5);
      tx_busy = 1'b1;
      tick;
      chk("a_begin_n3", tx_begin, 0);
      chk("a_grant_hold", grant, 4'b0010);
      tx_busy = 1'b0;
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      chk("a_count", sent_count, 1);
      chk("a_grant_clr", grant, 0);

      // busy hold-off with requester 0 pending
      tx_busy   = 1'b1;
      req_valid = 4'b0001;
      early     = 0;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (req_ready != 0 || tx_begin != 0) early++;
      end
      chk("hold_quiet", early, 0);
      tx_busy = 1'b0;
      tick;
      chk("hold_ready", req_ready, 4'b0001);
      chk("hold_grant", grant, 4'b0001);
      req_valid = '0;
      tick;
      chk("hold_begin", tx_begin, 1);
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      chk("hold_count", sent_count, 2);

      // timeout: last owner 0, requests 0 and 2 -> 2 wins, never busy or done
      req_valid = 4'b0101;
      tick;
      chk("to_grant", grant, 4'b0100);
      chk("to_data", tx_data, 8'h33);
      req_valid = '0;
      tick;
      chk("to_begin", tx_begin, 1);
      early = 0;
      for (int i = 0; i < 49; i++) begin
         tick;
         if (timeout) early++;
      end
      chk("to_early", early, 0);
      tick;
      chk("to_pulse", timeout, 1);
      chk("to_grant_hold", grant, 4'b0100);
      tick;
      chk("to_pulse_end", timeout, 0);
      chk("to_grant_clr", grant, 0);
      chk("to_count", sent_count, 2);

      // next grant after timeout goes to 3; then done collides with timeout
      req_valid = 4'b1111;
      tick;
      chk("col_grant", grant, 4'b1000);
      req_valid = '0;
      tick;
      chk("col_begin", tx_begin, 1);
      for (int i = 0; i < 50; i++) tick;
      tx_done = 1'b1;
      #1;
      chk("col_timeout", timeout, 0);
      tick;
      tx_done = 1'b0;
      chk("col_count", sent_count, 3);
      chk("col_grant_clr", grant, 0);

      // reset asserted during WAIT_DONE
      req_valid = 4'b0001;
      tick;
      chk("mr_grant", grant, 4'b0001);
      req_valid = '0;
      tick;
      tx_busy = 1'b1;
      tick;
      #2;
      resetN = 1'b0;
      #1;
      chk("mr_grant_async", grant, 0);
      chk("mr_count_async", sent_count, 0);
      chk("mr_data_async", tx_data, 0);
      tx_busy = 1'b0;
      tick;
      resetN = 1'b1;
      early = 0;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (tx_begin || grant != 0) early++;
      end
      chk("mr_no_begin", early, 0);

      // fairness from fresh reset: 0,1,2,3,0,1,2,3
      req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         tick;
         chk($sformatf("fair_grant%0d", i), grant, 4'b0001 << (i % 4));
         chk($sformatf("fair_data%0d", i), tx_data, fair_bytes[i % 4]);
         tick;
         tx_done = 1'b1;
         tick;
         tx_done = 1'b0;
      end
      req_valid = '0;
      chk("fair_count", sent_count, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
